// File: rtl/lane_address_sequencer.sv
// Multi-lane address sequencer for the banked NTT memory: strided modular count or lane rotation.
// Optional reverse stepping is enabled by defining LANE_ADDRGEN_REVERSE_EN, which adds the dir input.
module lane_address_sequencer #(
    parameter int LANES = 257,
    parameter int DEPTH = 85,
    parameter int SHIFT = 85,
    parameter int AW    = 8,
    parameter int CW    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                mode,
    input  logic [AW-1:0]       base,
    input  logic [AW-1:0]       stride,
    input  logic [CW-1:0]       steps,
`ifdef LANE_ADDRGEN_REVERSE_EN
    input  logic                dir,
`endif
    output logic [LANES*AW-1:0] addr,
    output logic                valid,
    input  logic                ready,
    output logic                last,
    output logic                busy,
    output logic                done
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    state_t              state_r, state_s;
    logic [LANES*AW-1:0] addr_r, addr_s, load_s, step_s;
    logic [CW-1:0]       cnt_r, cnt_s, steps_r, steps_s;
    logic [AW-1:0]       stride_r, stride_s;
    logic                mode_r, mode_s;
    logic                valid_r, last_r, last_s, busy_r, done_r;
    logic                run_start_s;

    assign run_start_s = start && (steps != CW'(0));

`ifdef LANE_ADDRGEN_REVERSE_EN
    logic dir_r;

    // Direction is captured together with the other run settings
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dir_r <= 1'b0;
        end else if ((state_r == IDLE) && run_start_s) begin
            dir_r <= dir;
        end else begin
            dir_r <= dir_r;
        end
    end
`endif

    // Rotation sources are fixed per lane, so the lane index arithmetic folds away at elaboration
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam int            FWD_SRC = (i + SHIFT) % LANES;
        localparam logic [AW-1:0] INIT    = AW'(i % DEPTH);
        logic [AW:0]   cur_s, sum_s;
        logic [AW-1:0] cnt_fwd_s, rot_fwd_s;

        assign cur_s     = {1'b0, addr_r[i*AW +: AW]};
        assign sum_s     = cur_s + {1'b0, stride_r};
        assign cnt_fwd_s = (sum_s >= DEPTH_W) ? AW'(sum_s - DEPTH_W) : sum_s[AW-1:0];
        assign rot_fwd_s = addr_r[FWD_SRC*AW +: AW];
`ifdef LANE_ADDRGEN_REVERSE_EN
        localparam int REV_SRC = (i + LANES - SHIFT) % LANES;
        logic [AW-1:0] cnt_rev_s;

        assign cnt_rev_s = (cur_s >= {1'b0, stride_r}) ? AW'(cur_s - {1'b0, stride_r})
                                                       : AW'(cur_s + DEPTH_W - {1'b0, stride_r});
        assign step_s[i*AW +: AW] = mode_r ? (dir_r ? addr_r[REV_SRC*AW +: AW] : rot_fwd_s)
                                           : (dir_r ? cnt_rev_s : cnt_fwd_s);
`else
        assign step_s[i*AW +: AW] = mode_r ? rot_fwd_s : cnt_fwd_s;
`endif
        assign load_s[i*AW +: AW] = mode ? INIT : base;
    end

    // Next-state and next-register values for the sequencer
    always_comb begin
        state_s  = state_r;
        addr_s   = addr_r;
        cnt_s    = cnt_r;
        last_s   = last_r;
        mode_s   = mode_r;
        stride_s = stride_r;
        steps_s  = steps_r;
        case (state_r)
            IDLE: begin
                if (run_start_s) begin
                    state_s  = RUN;
                    mode_s   = mode;
                    stride_s = stride;
                    steps_s  = steps;
                    addr_s   = load_s;
                    cnt_s    = CW'(0);
                    last_s   = (steps == CW'(1));
                end else if (start) begin
                    state_s = DONE;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (valid_r && ready && last_r) begin
                    state_s = DONE;
                    last_s  = 1'b0;
                end else if (valid_r && ready) begin
                    addr_s = step_s;
                    cnt_s  = cnt_r + CW'(1);
                    last_s = ((cnt_r + CW'(1)) == (steps_r - CW'(1)));
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, lane and registered status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= IDLE;
            addr_r   <= '0;
            cnt_r    <= CW'(0);
            steps_r  <= CW'(0);
            stride_r <= AW'(0);
            mode_r   <= 1'b0;
            valid_r  <= 1'b0;
            last_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            addr_r   <= addr_s;
            cnt_r    <= cnt_s;
            steps_r  <= steps_s;
            stride_r <= stride_s;
            mode_r   <= mode_s;
            valid_r  <= (state_s == RUN);
            last_r   <= last_s;
            busy_r   <= (state_s != IDLE);
            done_r   <= (state_s == DONE);
        end
    end

    assign addr  = addr_r;
    assign valid = valid_r;
    assign last  = last_r;
    assign busy  = busy_r;
    assign done  = done_r;
endmodule

// File: tb/tb_lane_address_sequencer.sv
// Directed bench for lane_address_sequencer with LANES=7, DEPTH=3, SHIFT=3, AW=2 and a narrow step counter.
module tb_lane_address_sequencer;
    localparam int LANES = 7;
    localparam int DEPTH = 3;
    localparam int SHIFT = 3;
    localparam int AW    = 2;
    localparam int CW    = 4;
    localparam int AWD   = LANES * AW;

    logic           clk = 1'b0;
    logic           reset, start, mode, ready;
    logic [AW-1:0]  base, stride;
    logic [CW-1:0]  steps;
    logic [AWD-1:0] addr;
    logic           valid, last, busy, done;
`ifdef LANE_ADDRGEN_REVERSE_EN
    logic           dir;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int seq_a [4] = '{1, 0, 2, 1};

    always #5 clk = ~clk;

    lane_address_sequencer #(
        .LANES(LANES), .DEPTH(DEPTH), .SHIFT(SHIFT), .AW(AW), .CW(CW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .base(base), .stride(stride), .steps(steps),
`ifdef LANE_ADDRGEN_REVERSE_EN
        .dir(dir),
`endif
        .addr(addr), .valid(valid), .ready(ready), .last(last),
        .busy(busy), .done(done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AWD-1:0] rep(input int v);
        logic [AWD-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) r[i*AW +: AW] = AW'(v);
        return r;
    endfunction

    function automatic logic [AWD-1:0] vec(input int l0, l1, l2, l3, l4, l5, l6);
        logic [AWD-1:0] r;
        r = {AW'(l6), AW'(l5), AW'(l4), AW'(l3), AW'(l2), AW'(l1), AW'(l0)};
        return r;
    endfunction

    task automatic launch(input logic m, input int b, input int s, input int n);
        mode = m; base = AW'(b); stride = AW'(s); steps = CW'(n); start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; mode = 1'b0; base = '0; stride = '0; steps = '0; ready = 1'b1;
`ifdef LANE_ADDRGEN_REVERSE_EN
        dir = 1'b0;
`endif
        #12;
        check("rst_addr", 32'(addr), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_last", 32'(last), 32'h0);
        reset = 1'b1;
        tick();

        // strided count 1,0,2,1
        launch(1'b0, 1, 2, 4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("s_addr%0d", k), 32'(addr), 32'(rep(seq_a[k])));
            check($sformatf("s_valid%0d", k), 32'(valid), 32'h1);
            check($sformatf("s_last%0d", k), 32'(last), 32'(k == 3));
            tick();
        end
        check("s_done", 32'(done), 32'h1);
        check("s_valid_drop", 32'(valid), 32'h0);
        check("s_hold", 32'(addr), 32'(rep(1)));
        tick();
        check("s_done_end", 32'(done), 32'h0);
        check("s_busy_end", 32'(busy), 32'h0);

        // rotation, with an ignored start during the run
        launch(1'b1, 0, 0, 2);
        check("r_v0", 32'(addr), 32'(vec(0, 1, 2, 0, 1, 2, 0)));
        check("r_last0", 32'(last), 32'h0);
        mode = 1'b0; base = AW'(2); steps = CW'(5); start = 1'b1;
        tick();
        start = 1'b0;
        check("r_v1", 32'(addr), 32'(vec(0, 1, 2, 0, 0, 1, 2)));
        check("r_last1", 32'(last), 32'h1);
        tick();
        check("r_done", 32'(done), 32'h1);
        tick();
        check("r_busy_end", 32'(busy), 32'h0);
        check("r_valid_end", 32'(valid), 32'h0);

        // stall with ready low on run cycles 2-4
        launch(1'b0, 0, 1, 3);
        check("st_c1", 32'(addr), 32'(rep(0)));
        tick();
        check("st_c2", 32'(addr), 32'(rep(1)));
        ready = 1'b0;
        for (int c = 3; c <= 5; c++) begin
            tick();
            check($sformatf("st_hold%0d", c), 32'(addr), 32'(rep(1)));
            check($sformatf("st_valid%0d", c), 32'(valid), 32'h1);
            check($sformatf("st_last%0d", c), 32'(last), 32'h0);
            check($sformatf("st_nodone%0d", c), 32'(done), 32'h0);
        end
        ready = 1'b1;
        tick();
        check("st_c6", 32'(addr), 32'(rep(2)));
        check("st_last6", 32'(last), 32'h1);
        tick();
        check("st_done", 32'(done), 32'h1);
        tick();
        check("st_done_once", 32'(done), 32'h0);

        // zero-step run
        launch(1'b0, 0, 1, 0);
        check("z_done", 32'(done), 32'h1);
        check("z_busy", 32'(busy), 32'h1);
        check("z_valid", 32'(valid), 32'h0);
        check("z_addr", 32'(addr), 32'(rep(2)));
        tick();
        check("z_done_end", 32'(done), 32'h0);
        check("z_busy_end", 32'(busy), 32'h0);
        check("z_valid_end", 32'(valid), 32'h0);

        // asynchronous reset mid-run
        launch(1'b0, 1, 2, 4);
        tick();
        tick();
        check("ar_v2", 32'(addr), 32'(rep(2)));
        #2 reset = 1'b0;
        #1;
        check("ar_addr", 32'(addr), 32'h0);
        check("ar_valid", 32'(valid), 32'h0);
        check("ar_busy", 32'(busy), 32'h0);
        check("ar_last", 32'(last), 32'h0);
        tick();
        reset = 1'b1;
        tick();
        check("ar_nodone", 32'(done), 32'h0);
        launch(1'b0, 1, 2, 2);
        check("ar_fresh0", 32'(addr), 32'(rep(1)));
        tick();
        check("ar_fresh1", 32'(addr), 32'(rep(0)));
        check("ar_fresh_last", 32'(last), 32'h1);
        tick();
        check("ar_fresh_done", 32'(done), 32'h1);
        tick();

        // full-range step count
        launch(1'b0, 0, 1, 15);
        for (int k = 0; k < 15; k++) begin
            check($sformatf("m_addr%0d", k), 32'(addr), 32'(rep(k % 3)));
            check($sformatf("m_last%0d", k), 32'(last), 32'(k == 14));
            tick();
        end
        check("m_done", 32'(done), 32'h1);
        tick();
        check("m_busy_end", 32'(busy), 32'h0);

`ifdef LANE_ADDRGEN_REVERSE_EN
        dir = 1'b1;
        seq_a = '{1, 2, 0, 1};
        launch(1'b0, 1, 2, 4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rv_addr%0d", k), 32'(addr), 32'(rep(seq_a[k])));
            tick();
        end
        tick();
        launch(1'b1, 0, 0, 2);
        check("rv_v0", 32'(addr), 32'(vec(0, 1, 2, 0, 1, 2, 0)));
        tick();
        check("rv_v1", 32'(addr), 32'(vec(1, 2, 0, 0, 1, 2, 0)));
        tick();
        tick();
        dir = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
